// File: rtl/reg_bank_arbiter.sv
// reg_bank_arbiter
//   Two-requester, round-robin arbiter that serialises single-cycle writes
//   into a bank of N_REG enable-gated registers. Each accepted request runs
//   IDLE -> GRANT -> WRITE, so the fixed latency is gnt one cycle after the
//   sampling edge and wen two cycles after it. All outputs are registered.
//
// Ports
//   clk            : single clock, rising-edge
//   rst            : synchronous, active-high reset
//   req0 / req1    : write request per requester
//   addr0 / addr1  : target register index per requester
//   data0 / data1  : write data per requester
//   gnt0 / gnt1    : one-cycle grant pulse to the winning requester
//   wen            : one-hot register write enable, high only in WRITE
//   wdata          : write data to every bank register, held outside WRITE
//   busy           : high in GRANT and WRITE
//
// state | meaning
// IDLE  | waiting for a request; arbitration and latching happen on exit
// GRANT | winner's gnt is high; requests are ignored
// WRITE | wen/wdata drive the bank for one cycle; requests are ignored
module reg_bank_arbiter #(
  parameter int DATA_W = 8,
  parameter int N_REG  = 4,
  localparam int ADDR_W = (N_REG > 1) ? $clog2(N_REG) : 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req0,
  input  logic              req1,
  input  logic [ADDR_W-1:0] addr0,
  input  logic [ADDR_W-1:0] addr1,
  input  logic [DATA_W-1:0] data0,
  input  logic [DATA_W-1:0] data1,
  output logic              gnt0,
  output logic              gnt1,
  output logic [N_REG-1:0]  wen,
  output logic [DATA_W-1:0] wdata,
  output logic              busy
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GRANT = 2'd1,
    WRITE = 2'd2
  } state_t;

  state_t              state_q, state_d;
  logic                last_winner_q, last_winner_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [DATA_W-1:0]   data_q, data_d;
  logic                gnt0_d, gnt1_d, busy_d;
  logic [N_REG-1:0]    wen_d;
  logic [DATA_W-1:0]   wdata_d;
  logic                win1;

  // Requester 1 wins when it is alone, or on a tie when requester 0 was
  // served last (last_winner_q == 0).
  assign win1 = req1 & (~req0 | ~last_winner_q);

  // State and registered outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= IDLE;
      last_winner_q <= 1'b1;
      addr_q        <= '0;
      data_q        <= '0;
      gnt0          <= 1'b0;
      gnt1          <= 1'b0;
      wen           <= '0;
      wdata         <= '0;
      busy          <= 1'b0;
    end else begin
      state_q       <= state_d;
      last_winner_q <= last_winner_d;
      addr_q        <= addr_d;
      data_q        <= data_d;
      gnt0          <= gnt0_d;
      gnt1          <= gnt1_d;
      wen           <= wen_d;
      wdata         <= wdata_d;
      busy          <= busy_d;
    end
  end

  // Next state
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (req0 || req1) state_d = GRANT;
      GRANT:   state_d = WRITE;
      WRITE:   state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Next values of the registered outputs and the latched transaction
  always_comb begin
    gnt0_d        = 1'b0;
    gnt1_d        = 1'b0;
    wen_d         = '0;
    wdata_d       = wdata;
    busy_d        = 1'b0;
    last_winner_d = last_winner_q;
    addr_d        = addr_q;
    data_d        = data_q;
    case (state_q)
      IDLE: begin
        if (req0 || req1) begin
          gnt0_d        = ~win1;
          gnt1_d        = win1;
          busy_d        = 1'b1;
          last_winner_d = win1;
          addr_d        = win1 ? addr1 : addr0;
          data_d        = win1 ? data1 : data0;
        end
      end
      GRANT: begin
        wen_d[addr_q] = 1'b1;
        wdata_d       = data_q;
        busy_d        = 1'b1;
      end
      default: ;
    endcase
  end

endmodule
